// File: rtl/reg_file_fwd.sv
// Dual-read GPR file for the decode stage: WB-written array with EX/MEM/WB operand
// forwarding merged into the read path and a combinational load-use stall request.
module reg_file_fwd #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_NUM        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      read_en_1,
    input  logic [REG_ADDR_WIDTH-1:0] read_addr_1,
    input  logic                      read_en_2,
    input  logic [REG_ADDR_WIDTH-1:0] read_addr_2,
    output logic [DATA_WIDTH-1:0]     read_data_1,
    output logic [DATA_WIDTH-1:0]     read_data_2,
    input  logic                      ex_write_en,
    input  logic [REG_ADDR_WIDTH-1:0] ex_write_addr,
    input  logic [DATA_WIDTH-1:0]     ex_write_data,
    input  logic                      ex_is_load,
    input  logic                      mem_write_en,
    input  logic [REG_ADDR_WIDTH-1:0] mem_write_addr,
    input  logic [DATA_WIDTH-1:0]     mem_write_data,
    input  logic                      write_en,
    input  logic [REG_ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0]     write_data,
    output logic                      stall_req
);

    typedef struct packed {
        logic                  hazard;
        logic [DATA_WIDTH-1:0] data;
    } rd_t;

    logic [DATA_WIDTH-1:0] regs [REG_NUM];
    rd_t                   port_1;
    rd_t                   port_2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en && write_addr != '0) begin
            regs[write_addr] <= write_data;
        end
    end

    // Youngest producer first; a load still in EX has no data yet, so flag it instead.
    function automatic rd_t resolve(input logic en, input logic [REG_ADDR_WIDTH-1:0] addr);
        rd_t r;
        r = '0;
        if (!en || addr == '0) begin
            r = '0;
        end else if (ex_write_en && ex_write_addr == addr) begin
            r.hazard = ex_is_load;
            r.data   = ex_is_load ? '0 : ex_write_data;
        end else if (mem_write_en && mem_write_addr == addr) begin
            r.data = mem_write_data;
        end else if (write_en && write_addr == addr) begin
            r.data = write_data;
        end else begin
            r.data = regs[addr];
        end
        return r;
    endfunction

    always_comb begin
        port_1 = resolve(read_en_1, read_addr_1);
        port_2 = resolve(read_en_2, read_addr_2);
    end

    assign read_data_1 = port_1.data;
    assign read_data_2 = port_2.data;
    assign stall_req   = port_1.hazard | port_2.hazard;

endmodule

// File: doc/reg_file_fwd.md
Name: reg_file_fwd

Overview:
- Register-file responder serving the decode stage's two read requests (enable + 5-bit address per port).
- Holds the 32x32 architectural GPR array, written by WB.
- Returns operand values combinationally with EX/MEM/WB forwarding merged in.
- Raises a load-use stall request when a read hits a load still in EX.

Parameters:
DATA_WIDTH, 32, width of a register / data word
REG_ADDR_WIDTH, 5, register address width
REG_NUM, 32, number of architectural registers (entry 0 hardwired zero)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-low reset
read_en_1  input  1  decode read request, port 1
read_addr_1  input  REG_ADDR_WIDTH  read address, port 1
read_en_2  input  1  decode read request, port 2
read_addr_2  input  REG_ADDR_WIDTH  read address, port 2
read_data_1  output  DATA_WIDTH  resolved operand, port 1
read_data_2  output  DATA_WIDTH  resolved operand, port 2
ex_write_en  input  1  EX-stage instruction will write a register
ex_write_addr  input  REG_ADDR_WIDTH  EX destination register
ex_write_data  input  DATA_WIDTH  EX ALU result
ex_is_load  input  1  EX instruction is a load (data not yet available)
mem_write_en  input  1  MEM-stage instruction will write a register
mem_write_addr  input  REG_ADDR_WIDTH  MEM destination register
mem_write_data  input  DATA_WIDTH  MEM final result (load data included)
write_en  input  1  WB write strobe
write_addr  input  REG_ADDR_WIDTH  WB destination register
write_data  input  DATA_WIDTH  WB data
stall_req  output  1  load-use hazard; decode must hold

Behaviour:
- Reset (rst=0, async): all REG_NUM entries cleared to 0 immediately.
  - read_data_1/2 follow the read rules below, so they read 0 unless a forward source is active.
  - stall_req follows its combinational rule.
  - Reset release is synchronous to clk in effect: no write lands on the release edge unless rst is already high before that edge.
- Write:
  - On rising clk with rst=1, write_en=1 and write_addr!=0: array[write_addr] <= write_data.
  - Writes to address 0 are discarded.
  - One write per cycle.
- Read, per port n, combinational, zero-cycle latency. Evaluate in priority order; first match wins:
  1. read_en_n=0 -> 0.
  2. read_addr_n=0 -> 0. No forwarding to $zero, even if a stage targets it.
  3. ex_write_en=1 and ex_write_addr=read_addr_n:
     - ex_is_load=0 -> ex_write_data.
     - ex_is_load=1 -> 0, and the port flags a hazard.
  4. mem_write_en=1 and mem_write_addr=read_addr_n -> mem_write_data.
  5. write_en=1 and write_addr=read_addr_n -> write_data (same-cycle WB bypass, write-first).
  6. Otherwise -> array[read_addr_n].
- Youngest producer wins: when EX, MEM and WB all target the same register, EX data is returned.
- stall_req = hazard_1 OR hazard_2.
  - hazard_n requires read_en_n=1, read_addr_n!=0, ex_write_en=1, ex_is_load=1 and address match.
  - stall_req is purely combinational, with no registered state.
  - Hold/flush of the pipeline is the controller's job.
- Both ports may read the same address. They resolve identically and independently.
- Widths: all comparisons are full REG_ADDR_WIDTH. Data is passed through unmodified; no sign handling.

Test Plan:
- Reset/zero:
  - Assert rst=0 mid-run after writing r5=0x1234.
  - Release, read r5 on port 1 -> 0x00000000; stall_req=0.
  - Write r0=0xFFFFFFFF, read r0 -> 0.
- Write/read:
  - WB writes r7=0xDEADBEEF; next cycle read port 2 addr 7 with write_en=0 -> 0xDEADBEEF.
  - Same read with read_en_2=0 -> 0.
- WB bypass:
  - Same cycle: write_en=1, write_addr=3, write_data=0xA5A5A5A5, read addr 3 -> 0xA5A5A5A5 before the edge.
  - Array holds the value after the edge.
- Forward priority:
  - r9 array=1, WB writes r9=2, MEM r9=3, EX r9=4 (non-load) -> read 4.
  - Drop EX -> 3; drop MEM -> 2.
- Load-use:
  - EX load to r4, port 1 reads r4 -> stall_req=1, read_data_1=0.
  - Same with read_en_1=0 -> stall_req=0.
  - EX load to r0 with port 1 reading r0 -> stall_req=0.
- Dual port:
  - Both ports read r12 while MEM forwards r12=0x55 -> both return 0x55.
  - Port 1 r12 / port 2 r13 (array 0x66) -> 0x55 / 0x66.
